// File: rtl/timer_counter_pkg.sv
// Shared definitions for the timer peripheral and the system bridge.
// - Register word offsets, CTRL bit positions, MODE encodings.
// - FSM state encoding.
// - Byte-lane merge helper used for partial-word stores.
package timer_counter_pkg;

  // Byte offsets seen by the block; only [3:2] are decoded.
  localparam logic [3:0] TC_CTRL   = 4'h0;
  localparam logic [3:0] TC_PRESET = 4'h4;
  localparam logic [3:0] TC_COUNT  = 4'h8;
  localparam logic [3:0] TC_RSVD   = 4'hC;

  // CTRL register layout: [0] EN, [2:1] MODE, [3] IM.
  localparam int unsigned CTRL_W        = 4;
  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StLoad = ST_LOAD,
    StCnt  = ST_CNT,
    StInt  = ST_INT
  } tc_state_e;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] wr_val,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? wr_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// CPU data-memory responder bus for the timer peripheral.
// - sel     : bridge decode hit, same cycle as addr
// - addr    : byte offset [3:0]
// - wd      : store data
// - byte_en : per-byte write enable, 0 means read / no write
// - rd      : combinational read data
interface timer_counter_if;
  logic        sel;
  logic [3:0]  addr;
  logic [31:0] wd;
  logic [3:0]  byte_en;
  logic [31:0] rd;

  modport master (output sel, addr, wd, byte_en, input rd);
  modport slave  (input sel, addr, wd, byte_en, output rd);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped timer peripheral.
// Ports:
// - clk   : system clock, rising edge
// - reset : asynchronous, active-low reset
// - bus   : CPU data-memory responder (timer_counter_if.slave)
// - irq   : interrupt request to the bridge / HWInt line
// CNT_W must be in 1..32; rd bits above CNT_W read 0.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int unsigned        CNT_W        = 32,
  parameter logic [CNT_W-1:0]   RESET_PRESET = '0
) (
  input  logic            clk,
  input  logic            reset,
  timer_counter_if.slave  bus,
  output logic            irq
);

  tc_state_e          state_q, state_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   preset_q, preset_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               irq_flag_q, irq_flag_d;

  logic [1:0]   word;
  logic         wr_en;
  logic         ctrl_wr;
  logic         preset_wr;
  logic         ctrl_en;
  logic         reload_mode;
  logic [31:0]  ctrl_ext;
  logic [31:0]  preset_ext;
  logic [31:0]  count_ext;
  logic [31:0]  preset_merged;
  logic         unused_addr;

  assign word        = bus.addr[3:2];
  assign unused_addr = ^bus.addr[1:0];
  assign wr_en       = bus.sel && (bus.byte_en != 4'b0000);
  assign ctrl_wr     = wr_en && (word == TC_CTRL[3:2]);
  assign preset_wr   = wr_en && (word == TC_PRESET[3:2]);

  assign ctrl_en     = ctrl_q[CTRL_EN_BIT];
  // MODE 1x falls back to one-shot.
  assign reload_mode = (ctrl_q[CTRL_MODE_LSB +: 2] == MODE_RELOAD);

  always_comb begin
    ctrl_ext             = '0;
    ctrl_ext[CTRL_W-1:0] = ctrl_q;
    preset_ext           = '0;
    preset_ext[CNT_W-1:0] = preset_q;
    count_ext            = '0;
    count_ext[CNT_W-1:0] = count_q;
  end

  assign preset_merged = merge_bytes(preset_ext, bus.wd, bus.byte_en);

  // Next-state: FSM first, CPU writes afterwards so they take priority.
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    unique case (state_q)
      StIdle: begin
        if (ctrl_en) state_d = StLoad;
      end
      StLoad: begin
        if (!ctrl_en) begin
          state_d = StIdle;
        end else begin
          count_d = preset_q;
          state_d = StCnt;
        end
      end
      StCnt: begin
        if (!ctrl_en) begin
          state_d = StIdle;
        end else if (count_q > CNT_W'(1)) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          // Covers PRESET=0 too; never wraps below zero.
          count_d    = '0;
          irq_flag_d = 1'b1;
          state_d    = StInt;
        end
      end
      StInt: begin
        if (reload_mode) begin
          irq_flag_d = 1'b0;
          // EN still set: reload straight away so the period is PRESET+2.
          state_d    = ctrl_en ? StLoad : StIdle;
        end else begin
          ctrl_d[CTRL_EN_BIT] = 1'b0;
          state_d             = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (ctrl_wr) begin
      if (bus.byte_en[0]) ctrl_d = bus.wd[CTRL_W-1:0];
      else                ctrl_d = ctrl_q;
      irq_flag_d = 1'b0;
    end
    if (preset_wr) begin
      preset_d = preset_merged[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      ctrl_q     <= '0;
      preset_q   <= RESET_PRESET;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    bus.rd = '0;
    if (bus.sel) begin
      case (word)
        TC_CTRL[3:2]:   bus.rd = ctrl_ext;
        TC_PRESET[3:2]: bus.rd = preset_ext;
        TC_COUNT[3:2]:  bus.rd = count_ext;
        default:        bus.rd = '0;
      endcase
    end
  end

  assign irq = irq_flag_q & ctrl_q[CTRL_IM_BIT];

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;

  logic clk = 1'b0;
  logic reset;
  logic irq;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  timer_counter_if bus ();

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .irq   (irq)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one rising edge, then sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.sel     = 1'b1;
    bus.addr    = a;
    bus.wd      = d;
    bus.byte_en = be;
    tick();
    bus.sel     = 1'b0;
    bus.byte_en = 4'b0000;
  endtask

  task automatic expect_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus.sel     = 1'b1;
    bus.addr    = a;
    bus.byte_en = 4'b0000;
    #1;
    v = bus.rd;
    bus.sel = 1'b0;
    check_eq(tag, v, exp);
  endtask

  task automatic expect_irq(input string tag, input logic exp);
    check_eq(tag, {31'b0, irq}, {31'b0, exp});
  endtask

  initial begin
    reset       = 1'b0;
    bus.sel     = 1'b0;
    bus.addr    = 4'h0;
    bus.wd      = 32'h0;
    bus.byte_en = 4'b0000;
    repeat (3) tick();
    expect_reg("rst_ctrl", 4'h0, 32'h0);
    expect_reg("rst_preset", 4'h4, 32'h0);
    expect_reg("rst_count", 4'h8, 32'h0);
    expect_irq("rst_irq", 1'b0);
    reset = 1'b1;
    tick();

    // Reset asserted mid-count.
    bus_write(4'h4, 32'd5, 4'hF);
    bus_write(4'h0, 32'h9, 4'hF);
    repeat (3) tick();
    expect_reg("midcnt_count", 4'h8, 32'd4);
    reset = 1'b0;
    #1;
    expect_reg("midrst_ctrl", 4'h0, 32'h0);
    expect_reg("midrst_count", 4'h8, 32'h0);
    expect_reg("midrst_preset", 4'h4, 32'h0);
    expect_irq("midrst_irq", 1'b0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    expect_reg("post_rst_count", 4'h8, 32'h0);
    expect_reg("post_rst_ctrl", 4'h0, 32'h0);

    // One-shot: PRESET=3, EN+IM.
    bus_write(4'h4, 32'd3, 4'hF);
    bus_write(4'h0, 32'h9, 4'hF);
    tick();
    expect_reg("os_load_count", 4'h8, 32'd0);
    for (int k = 3; k >= 0; k--) begin
      tick();
      expect_reg($sformatf("os_count_%0d", k), 4'h8, k);
      expect_irq($sformatf("os_irq_at_%0d", k), k == 0);
    end
    tick();
    expect_reg("os_ctrl_en_clear", 4'h0, 32'h8);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_irq($sformatf("os_irq_hold_%0d", k), 1'b1);
    end
    expect_reg("os_count_stays0", 4'h8, 32'd0);
    bus_write(4'h0, 32'h0, 4'hF);
    expect_irq("os_irq_cleared", 1'b0);

    // Auto-reload: PRESET=2, period 4.
    bus_write(4'h4, 32'd2, 4'hF);
    bus_write(4'h0, 32'hB, 4'hF);
    for (int k = 1; k <= 21; k++) begin
      logic [31:0] exp_cnt;
      tick();
      case (k % 4)
        2:       exp_cnt = 32'd2;
        3:       exp_cnt = 32'd1;
        default: exp_cnt = 32'd0;
      endcase
      if (k == 1) exp_cnt = 32'd0;
      expect_reg($sformatf("ar_count_k%0d", k), 4'h8, exp_cnt);
      expect_irq($sformatf("ar_irq_k%0d", k), (k % 4) == 0);
    end
    bus_write(4'h0, 32'h0, 4'hF);
    tick();
    expect_irq("ar_stop_irq", 1'b0);

    // Pause / resume.
    bus_write(4'h4, 32'd10, 4'hF);
    bus_write(4'h0, 32'h1, 4'hF);
    repeat (5) tick();
    expect_reg("pz_count7", 4'h8, 32'd7);
    bus_write(4'h0, 32'h0, 4'hF);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_reg($sformatf("pz_hold_%0d", k), 4'h8, 32'd6);
      expect_irq($sformatf("pz_irq_%0d", k), 1'b0);
    end
    bus_write(4'h0, 32'h1, 4'hF);
    tick();
    expect_reg("pz_resume_pre", 4'h8, 32'd6);
    tick();
    expect_reg("pz_reload10", 4'h8, 32'd10);
    bus_write(4'h0, 32'h0, 4'hF);
    tick();

    // Byte enables and ignored locations.
    bus_write(4'h4, 32'h11223344, 4'hF);
    bus_write(4'h4, 32'hAABBCCDD, 4'b0101);
    expect_reg("be_preset", 4'h4, 32'h11BB33DD);
    bus_write(4'h8, 32'hFFFFFFFF, 4'hF);
    expect_reg("be_count_ro", 4'h8, 32'd9);
    bus_write(4'hC, 32'hFFFFFFFF, 4'hF);
    expect_reg("be_rsvd_rd", 4'hC, 32'h0);
    expect_reg("be_preset_kept", 4'h4, 32'h11BB33DD);
    expect_reg("be_ctrl_kept", 4'h0, 32'h0);
    bus.addr = 4'h4;
    #1;
    check_eq("nosel_rd", bus.rd, 32'h0);

    // Masked one-shot: flag set, irq stays low.
    bus_write(4'h4, 32'd1, 4'hF);
    bus_write(4'h0, 32'h1, 4'hF);
    for (int k = 0; k < 6; k++) begin
      tick();
      expect_irq($sformatf("mask_irq_%0d", k), 1'b0);
    end
    expect_reg("mask_ctrl", 4'h0, 32'h0);
    bus_write(4'h0, 32'h8, 4'hF);
    expect_irq("mask_im_set_irq", 1'b0);
    tick();
    expect_irq("mask_im_set_irq2", 1'b0);

    // CTRL write in the INT cycle wins over the EN clear.
    bus_write(4'h0, 32'h9, 4'hF);
    repeat (3) tick();
    expect_irq("col_irq_up", 1'b1);
    bus_write(4'h0, 32'h9, 4'hF);
    expect_reg("col_ctrl_kept", 4'h0, 32'h9);
    expect_irq("col_irq_cleared", 1'b0);
    repeat (3) tick();
    expect_irq("col_restart_irq", 1'b1);
    bus_write(4'h0, 32'h0, 4'hF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
